multi_channel_interval_timer: RTL and testbench
===============================================

// Module: multi_channel_interval_timer
// PURPOSE
//  Parametrised N-channel down-counting interval timer for the audio recorder datapath.
//  - Each channel is programmed with a period and a mode (one-shot or periodic) and is
//    clocked by a shared prescaler tick.
//  - On expiry it emits a 1-cycle trigger and sets a sticky done flag. Done holds until
//    the consumer confirms it.
//  - Drives sample-rate strobes and record/playback length limits.
// PARAMETERS
//  WIDTH     18      counter/period width in bits
//  NUM_CH    4       number of independent channels (1..16)
//  PRESCALE  1       clock cycles per tick (>=1); 1 = tick every clock
//  CH_W      $clog2(NUM_CH) (min 1)   channel-select width, derived
// PORTS
//  clock      in   1              system clock, rising edge
//  reset      in   1              asynchronous, active-high; clears all state
//  cfg_we     in   1              write config for channel cfg_ch this cycle
//  cfg_ch     in   CH_W           channel being configured
//  cfg_period in   WIDTH          period in ticks; 0 = channel disabled
//  cfg_mode   in   1              0 = one-shot, 1 = periodic
//  start      in   NUM_CH         per-channel start/restart request, level sampled per cycle
//  stop       in   NUM_CH         per-channel stop request
//  Confirmed  in   NUM_CH         per-channel acknowledge; clears DoneSig
//  Trigger    out  NUM_CH         1-cycle expiry pulse per channel
//  DoneSig    out  NUM_CH         sticky expiry flag per channel
//  overrun    out  NUM_CH         sticky: expiry occurred while DoneSig already set
//  running    out  NUM_CH         channel in RUN state
//  count      out  NUM_CH*WIDTH   current count; channel i at [i*WIDTH +: WIDTH]
// BEHAVIOUR
//  Reset
//  - All outputs are 0. Every channel is in IDLE with period=0 and mode=one-shot.
//  - The prescaler is cleared.
//  Prescaler
//  - Free-running from reset. tick=1 on every PRESCALE-th clock.
//  - With PRESCALE=1, tick is always 1.
//  Config
//  - cfg_we writes period/mode registers of cfg_ch; cfg_ch >= NUM_CH is ignored.
//  - A write to a RUN channel does not disturb its count. The new period applies at the
//    next reload or start.
//  Per-channel FSM (IDLE, RUN)
//  - IDLE -> RUN: start=1 and period!=0; count <= period on the next edge. If period==0,
//    start is ignored.
//  - RUN, start=1: restart; count <= period, no trigger.
//  - RUN, stop=1: -> IDLE; count holds. stop beats start in the same cycle.
//  - RUN, tick=1, count>1: count <= count-1.
//  - RUN, tick=1, count==1: expiry.
//    - Trigger=1 for exactly that next cycle; DoneSig <= 1.
//    - If DoneSig was already 1 and not being cleared, overrun <= 1.
//    - Periodic: count <= period (reloaded), stays RUN.
//    - One-shot: count <= 0, -> IDLE.
//  - Expiry with stop in the same cycle: stop wins; no trigger.
//  Timing
//  - Start sampled at edge k with PRESCALE=1 and period P: Trigger is high in the cycle
//    after edge k+P. Exactly P ticks from load to expiry; periodic repeats every P ticks.
//  Handshake
//  - Confirmed=1 clears DoneSig and overrun on the next edge.
//  - Confirmed with simultaneous expiry: DoneSig stays 1 (set wins); overrun is not set.
//  - Confirmed while DoneSig=0: no effect.
//  Width
//  - Counts are unsigned WIDTH bits and never wrap below 0.
//  - Max period 2^WIDTH-1 ticks.
//  Reset mid-operation
//  - Asynchronous return to reset values, including a Trigger pulse in progress.
// STRUCTURE
//  - timer_pkg: typedef enum logic {ONE_SHOT, PERIODIC} timer_mode_t;
//    typedef enum logic {T_IDLE, T_RUN} timer_state_t.
//  - Sub-module timer_channel (WIDTH): one FSM, counter, period/mode registers, and
//    done/overrun logic.
//  - Top level holds the prescaler, the cfg decode, and a generate loop of NUM_CH
//    timer_channel instances.
// TESTING (NUM_CH=4, WIDTH=18, PRESCALE=1 unless noted)
//  - Reset held 5 cycles: all outputs 0.
//    Release, cfg ch0 period=10 one-shot, start pulse: Trigger[0] pulses once 10 cycles
//    after the load edge; DoneSig[0]=1, running[0]=0.
//  - ch1 period=3 periodic, never confirmed: Trigger[1] every 3 cycles.
//    overrun[1]=1 after the 2nd pulse. Confirmed[1] clears both.
//  - Confirmed[2] asserted in the same cycle as ch2 expiry: DoneSig[2] remains 1,
//    overrun[2]=0.
//  - ch3 period=0, start: stays IDLE, no Trigger.
//    Then start and stop together on a running channel: channel goes IDLE with count held.
//  - PRESCALE=4, ch0 period=5 periodic: Trigger spacing exactly 20 clocks.
//    Reconfigure to period 2 mid-run: the old interval completes, then spacing is
//    8 clocks.
//  - Reset asserted mid-count (count=7): outputs 0 asynchronously. After release, no
//    Trigger without a new start.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared mode and state encodings for the interval timer channels
package timer_pkg;
    typedef enum logic {ONE_SHOT, PERIODIC} timer_mode_t;
    typedef enum logic {T_IDLE, T_RUN} timer_state_t;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counting interval timer with period/mode registers and done/overrun flags
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             confirmed,
    output logic             trigger,
    output logic             done,
    output logic             overrun,
    output logic             running,
    output logic [WIDTH-1:0] count
);
    timer_state_t     state, state_n;
    timer_mode_t      mode;
    logic [WIDTH-1:0] period, count_n;
    logic             expire;
    assign running = (state == T_RUN);
    always_comb begin
        state_n = state;
        count_n = count;
        expire  = 1'b0;
        if (state == T_IDLE) begin
            if (start && period != '0) begin
                state_n = T_RUN;
                count_n = period;
            end
        end else if (stop) begin
            state_n = T_IDLE;
        end else if (start) begin
            count_n = period;
        end else if (tick) begin
            if (count > WIDTH'(1)) begin
                count_n = count - WIDTH'(1);
            end else begin
                expire = 1'b1;
                // a periodic channel reprogrammed to 0 falls back to idle instead of re-arming
                if (mode == PERIODIC && period != '0) begin
                    count_n = period;
                end else begin
                    count_n = '0;
                    state_n = T_IDLE;
                end
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= T_IDLE;
            mode    <= ONE_SHOT;
            period  <= '0;
            count   <= '0;
            trigger <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            trigger <= expire;
            done    <= expire | (done & ~confirmed);
            overrun <= ~confirmed & (overrun | (expire & done));
            if (cfg_we) begin
                period <= cfg_period;
                mode   <= timer_mode_t'(cfg_mode);
            end
        end
    end
endmodule

// File: rtl/multi_channel_interval_timer.sv
// multi_channel_interval_timer: shared prescaler and config decode feeding NUM_CH timer channels
module multi_channel_interval_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 18,
    parameter int NUM_CH   = 4,
    parameter int PRESCALE = 1,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [WIDTH-1:0]        cfg_period,
    input  logic                    cfg_mode,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       Confirmed,
    output logic [NUM_CH-1:0]       Trigger,
    output logic [NUM_CH-1:0]       DoneSig,
    output logic [NUM_CH-1:0]       overrun,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH*WIDTH-1:0] count
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pcnt;
    logic          tick;
    assign tick = (pcnt == PW'(PRESCALE - 1));
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pcnt <= '0;
        else       pcnt <= tick ? '0 : pcnt + PW'(1);
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clock      (clock),
            .reset      (reset),
            .tick       (tick),
            .cfg_we     (cfg_we && cfg_ch == CH_W'(i)),
            .cfg_period (cfg_period),
            .cfg_mode   (cfg_mode),
            .start      (start[i]),
            .stop       (stop[i]),
            .confirmed  (Confirmed[i]),
            .trigger    (Trigger[i]),
            .done       (DoneSig[i]),
            .overrun    (overrun[i]),
            .running    (running[i]),
            .count      (count[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// tb_multi_channel_interval_timer: directed and random checks of two timers (PRESCALE 1 and 4)
module tb_multi_channel_interval_timer;
    localparam int W = 18, N = 4;
    logic clock = 1'b0, reset = 1'b1;
    logic cfg_we = 1'b0, cfg_mode = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [W-1:0] cfg_period = '0;
    logic [N-1:0] start = '0, stop = '0, confirmed = '0;
    logic [N-1:0] trig_a, done_a, ovr_a, run_a, trig_b, done_b, ovr_b, run_b;
    logic [N*W-1:0] cnt_a, cnt_b;
    int total = 0, bad = 0, cyc = 0, ntrig = 0;
    int tq[$];
    logic [W-1:0] m_per[2][N], m_cnt[2][N];
    bit m_mode[2][N], m_run[2][N], m_trig[2][N], m_done[2][N], m_ovr[2][N];
    int m_edges[2];

    always #5 clock = ~clock;

    multi_channel_interval_timer #(.WIDTH(W), .NUM_CH(N), .PRESCALE(1)) dut_a (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_mode(cfg_mode), .start(start), .stop(stop), .Confirmed(confirmed), .Trigger(trig_a),
        .DoneSig(done_a), .overrun(ovr_a), .running(run_a), .count(cnt_a));
    multi_channel_interval_timer #(.WIDTH(W), .NUM_CH(N), .PRESCALE(4)) dut_b (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_mode(cfg_mode), .start(start), .stop(stop), .Confirmed(confirmed), .Trigger(trig_b),
        .DoneSig(done_b), .overrun(ovr_b), .running(run_b), .count(cnt_b));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_edges[d] = 0;
            for (int c = 0; c < N; c++) begin
                m_per[d][c] = '0; m_cnt[d][c] = '0; m_mode[d][c] = 0; m_run[d][c] = 0;
                m_trig[d][c] = 0; m_done[d][c] = 0; m_ovr[d][c] = 0;
            end
        end
    endtask

    // one clock edge of the behavioural model; ticks are every PRESCALE-th edge since reset
    task automatic model_edge();
        bit tick, ex;
        for (int d = 0; d < 2; d++) begin
            tick = (m_edges[d] % (d ? 4 : 1)) == (d ? 3 : 0);
            m_edges[d]++;
            for (int c = 0; c < N; c++) begin
                ex = 0;
                if (m_run[d][c]) begin
                    if (stop[c]) m_run[d][c] = 0;
                    else if (start[c]) m_cnt[d][c] = m_per[d][c];
                    else if (tick) begin
                        if (m_cnt[d][c] > 1) m_cnt[d][c] = m_cnt[d][c] - 1;
                        else begin
                            ex = 1;
                            if (m_mode[d][c] && m_per[d][c] != 0) m_cnt[d][c] = m_per[d][c];
                            else begin m_cnt[d][c] = 0; m_run[d][c] = 0; end
                        end
                    end
                end else if (start[c] && m_per[d][c] != 0) begin
                    m_run[d][c] = 1;
                    m_cnt[d][c] = m_per[d][c];
                end
                m_ovr[d][c] = !confirmed[c] && (m_ovr[d][c] || (ex && m_done[d][c]));
                m_done[d][c] = ex || (m_done[d][c] && !confirmed[c]);
                m_trig[d][c] = ex;
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_per[d][c] = cfg_period;
                    m_mode[d][c] = cfg_mode;
                end
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] et, ed, eo, er;
        logic [N*W-1:0] ec;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                et[c] = m_trig[d][c]; ed[c] = m_done[d][c]; eo[c] = m_ovr[d][c]; er[c] = m_run[d][c];
                ec[c*W +: W] = m_cnt[d][c];
            end
            chk($sformatf("trig%0d", d), d ? trig_b : trig_a, et);
            chk($sformatf("done%0d", d), d ? done_b : done_a, ed);
            chk($sformatf("ovr%0d", d), d ? ovr_b : ovr_a, eo);
            chk($sformatf("run%0d", d), d ? run_b : run_a, er);
            chk($sformatf("cnt%0d", d), d ? cnt_b : cnt_a, ec);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            if (reset) model_reset(); else model_edge();
            @(negedge clock);
            compare();
            cyc++;
            if (trig_b[0]) tq.push_back(cyc);
            if (|trig_a || |trig_b) ntrig++;
        end
    endtask

    task automatic set_cfg(input int ch, input int per, input bit mode);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = W'(per); cfg_mode = mode;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] s, input logic [N-1:0] p, input logic [N-1:0] k);
        start = s; stop = p; confirmed = k;
        step();
        start = '0; stop = '0; confirmed = '0;
    endtask

    initial begin
        int i;
        model_reset();
        step(5);
        chk("rst_out", {trig_a, done_a, ovr_a, run_a, cnt_a}, '0);
        reset = 1'b0;
        // one-shot, period 10
        set_cfg(0, 10, 0);
        pulse(4'b0001, '0, '0);
        i = 0;
        while (!trig_a[0] && i < 20) begin step(); i++; end
        chk("os_lat", i, 10);
        chk("os_done", done_a[0], 1);
        chk("os_run", run_a[0], 0);
        step();
        chk("os_once", trig_a[0], 0);
        // periodic, period 3, never confirmed
        set_cfg(1, 3, 1);
        pulse(4'b0010, '0, '0);
        i = 0;
        while (!trig_a[1] && i < 10) begin step(); i++; end
        chk("p_first", i, 3);
        chk("p_ovr1", ovr_a[1], 0);
        i = 0;
        do begin step(); i++; end while (!trig_a[1] && i < 10);
        chk("p_gap", i, 3);
        chk("p_ovr2", ovr_a[1], 1);
        pulse('0, '0, 4'b0010);
        chk("p_cf_done", done_a[1], 0);
        chk("p_cf_ovr", ovr_a[1], 0);
        pulse('0, 4'b0010, '0);
        chk("p_stop", run_a[1], 0);
        // confirm coincident with expiry while done already set
        set_cfg(2, 4, 0);
        pulse(4'b0100, '0, '0);
        step(4);
        chk("c2_done1", done_a[2], 1);
        pulse(4'b0100, '0, '0);
        step(3);
        pulse('0, '0, 4'b0100);
        chk("c2_trig", trig_a[2], 1);
        chk("c2_done", done_a[2], 1);
        chk("c2_ovr", ovr_a[2], 0);
        // period 0 start is ignored; start+stop together stops and holds count
        set_cfg(3, 0, 0);
        pulse(4'b1000, '0, '0);
        step(3);
        chk("z_run", run_a[3], 0);
        set_cfg(3, 50, 1);
        pulse(4'b1000, '0, '0);
        step(4);
        pulse(4'b1000, 4'b1000, '0);
        chk("ss_run", run_a[3], 0);
        chk("ss_cnt", cnt_a[3*W +: W], 46);
        // prescale 4 spacing, then reconfigure mid-run
        set_cfg(0, 5, 1);
        pulse(4'b0001, '0, '0);
        tq.delete();
        step(50);
        set_cfg(0, 2, 1);
        step(60);
        chk("ps_nq", tq.size() >= 5, 1);
        if (tq.size() >= 5) begin
            chk("ps_gap1", tq[1] - tq[0], 20);
            chk("ps_gap2", tq[2] - tq[1], 20);
            chk("ps_gap3", tq[3] - tq[2], 8);
            chk("ps_gap4", tq[4] - tq[3], 8);
        end
        pulse('0, '1, '1);
        // asynchronous reset mid-count
        set_cfg(1, 20, 0);
        pulse(4'b0010, '0, '0);
        step(13);
        chk("ar_cnt7", cnt_a[W +: W], 7);
        #2 reset = 1'b1;
        #1;
        chk("ar_a", {trig_a, done_a, ovr_a, run_a, cnt_a}, '0);
        chk("ar_b", {trig_b, done_b, ovr_b, run_b, cnt_b}, '0);
        model_reset();
        step(3);
        reset = 1'b0;
        ntrig = 0;
        step(25);
        chk("ar_notrig", ntrig, 0);
        // random traffic against the model
        repeat (3000) begin
            cfg_we = ($urandom % 8) == 0;
            cfg_ch = 2'($urandom);
            cfg_period = W'($urandom_range(0, 9));
            cfg_mode = 1'($urandom);
            for (int c = 0; c < N; c++) begin
                start[c] = ($urandom % 16) == 0;
                stop[c] = ($urandom % 32) == 0;
                confirmed[c] = ($urandom % 6) == 0;
            end
            if ($urandom % 500 == 0) begin
                #2 reset = 1'b1;
                #1 model_reset();
                step(2);
                reset = 1'b0;
            end
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
